// File: rtl/hilo_mult_sequencer.sv
// Iterative radix-2 shift-add multiplier for the HI/LO resource (mult/multu).
// Holds FETCH/EX while a HI/LO reader or a new multiply collides with an active one.
module hilo_mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       regsel_EX,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             stall_FETCH
);

  // state | meaning
  // IDLE  | waiting for start; HI/LO hold last product
  // RUN   | WIDTH shift-add iterations on operand magnitudes
  // FIX   | apply sign, write HI/LO, pulse done next cycle
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Most-negative operand negates to itself, which is the correct unsigned magnitude.
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
  assign sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
  assign prod  = neg_q ? -acc_q : acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = {sum, acc_q[WIDTH-1:1]};
        else             acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
      FIX: begin
        {hi_d, lo_d} = prod;
        done_d       = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q == RUN) || (state_q == FIX);
    stall_FETCH = busy & (start | (regsel_EX == 2'd1) | (regsel_EX == 2'd2));
    done        = done_q;
    hi_out      = hi_q;
    lo_out      = lo_q;
  end

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Directed bench for hilo_mult_sequencer with a product scoreboard.
module tb_hilo_mult_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a, b;
  logic [1:0]   regsel_EX;
  logic [W-1:0] hi_out, lo_out;
  logic         busy, done, stall_FETCH;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  hilo_mult_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .regsel_EX(regsel_EX),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
    .stall_FETCH(stall_FETCH)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic sg, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ex, ey;
    ex = sg ? {{32{x[31]}}, x} : {32'b0, x};
    ey = sg ? {{32{y[31]}}, y} : {32'b0, y};
    return ex * ey;
  endfunction

  task automatic present(input logic sg, input logic [31:0] x, input logic [31:0] y);
    is_signed = sg;
    a         = x;
    b         = y;
    start     = 1'b1;
    exp_q.push_back(model(sg, x, y));
  endtask

  task automatic drive_start(input logic sg, input logic [31:0] x, input logic [31:0] y);
    present(sg, x, y);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered in the first busy cycle; leaves one cycle after the done cycle.
  task automatic wait_done(input string tag, input logic exp_stall);
    int bc;
    bit got;
    logic [63:0] e;
    bc  = 0;
    got = 0;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      if (busy === 1'b1) begin
        bc++;
        chk({tag, " stall"}, 64'(stall_FETCH), 64'(exp_stall));
      end
      @(negedge clk);
      #1;
    end
    chk({tag, " done seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, " busy cycles"}, 64'(bc), 64'd33);
      chk({tag, " busy in done"}, 64'(busy), 64'd0);
      chk({tag, " stall in done"}, 64'(stall_FETCH), 64'd0);
      chk({tag, " sb nonempty"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({tag, " hilo"}, {hi_out, lo_out}, e);
      end
      @(negedge clk);
      #1;
      chk({tag, " done pulse"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    bit saw_done;
    rst       = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    regsel_EX = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset hi", 64'(hi_out), 64'd0);
    chk("reset lo", 64'(lo_out), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset stall", 64'(stall_FETCH), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    drive_start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu max", 1'b0);
    chk("multu max hi", 64'(hi_out), 64'hFFFF_FFFE);
    chk("multu max lo", 64'(lo_out), 64'h0000_0001);

    drive_start(1'b1, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult -3*5", 1'b0);
    drive_start(1'b0, 32'hFFFF_FFFD, 32'd5);
    wait_done("multu -3*5", 1'b0);
    chk("multu -3*5 hi", 64'(hi_out), 64'h0000_0004);
    drive_start(1'b1, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult min*min", 1'b0);
    chk("mult min*min hi", 64'(hi_out), 64'h4000_0000);
    drive_start(1'b1, 32'h8000_0000, 32'd1);
    wait_done("mult min*1", 1'b0);
    chk("mult min*1 lo", 64'(lo_out), 64'h8000_0000);

    // mflo waiting on an active multiply
    drive_start(1'b1, 32'd7, 32'd6);
    regsel_EX = 2'd2;
    wait_done("mflo wait", 1'b1);
    chk("mflo wait lo", 64'(lo_out), 64'd42);
    regsel_EX = 2'd3;
    drive_start(1'b1, 32'd7, 32'd6);
    wait_done("regsel3", 1'b0);
    regsel_EX = 2'd0;

    // second start held while busy, accepted in the done cycle
    drive_start(1'b0, 32'd3, 32'd4);
    present(1'b0, 32'd5, 32'd5);
    wait_done("busy start first", 1'b1);
    chk("busy start first lo", 64'(lo_out), 64'd12);
    start = 1'b0;
    wait_done("busy start second", 1'b0);
    chk("busy start second lo", 64'(lo_out), 64'd25);

    drive_start(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mult -1*-1", 1'b0);
    drive_start(1'b1, 32'h7FFF_FFFF, 32'h8000_0001);
    wait_done("mult max*-max", 1'b0);

    // abort by reset mid-run
    drive_start(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done("preload", 1'b0);
    drive_start(1'b1, 32'h1111_1111, 32'h2222_2222);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("abort hi", 64'(hi_out), 64'd0);
    chk("abort lo", 64'(lo_out), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    exp_q.delete();
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("no stale activity", 64'(saw_done), 64'd0);
    chk("no stale hilo", {hi_out, lo_out}, 64'd0);
    drive_start(1'b0, 32'h0000_BEEF, 32'h0000_1234);
    wait_done("post reset", 1'b0);

    chk("sb drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
